dma_periph_requester: RTL
=========================

// Module: dma_periph_requester
// PURPOSE
// I/O-device end of the 8237A DMA channel protocol: raises DREQ, answers DACK with
// IOR_N/IOW_N data-bus cycles, drives/senses EOP_N. Buffers device data in a small FIFO.
// Instanced once per DMA-capable peripheral model; pairs with one 8237A channel.
// PARAMETERS
// DATA_W      8   data bus / FIFO word width
// FIFO_DEPTH  8   FIFO entries (power of 2, >=2)
// CNT_W       16  width of block-length counter
// PORTS
// CLK          in   1       system clock, same as DMA controller clock
// RESET        in   1       asynchronous, active-low reset
// cfg_enable   in   1       channel armed; rising edge loads cfg_len
// cfg_dir      in   1       0 = dev->mem (DMA write, IOR_N cycles); 1 = mem->dev (IOW_N cycles)
// cfg_demand   in   1       1 = demand mode (hold DREQ); 0 = single (drop DREQ per transfer)
// cfg_len      in   CNT_W   transfers in block; 0 means 2**CNT_W
// dev_wdata/dev_wvalid/dev_wready  in/in/out  DATA_W/1/1  device push (dir=0)
// dev_rdata/dev_rvalid/dev_rready  out/out/in DATA_W/1/1  device pop (dir=1)
// DREQ         out  1       DMA request, active high
// DACK         in   1       DMA acknowledge, active high
// IOR_N/IOW_N  in   1       I/O read/write strobes, active low
// DB_IN        in   DATA_W  data bus from DMA side
// DB_OUT/DB_OE out  DATA_W/1 data driven during IOR_N cycle
// EOP_N_IN     in   1       sensed EOP (TC from controller)
// EOP_N_OUT    out  1       0 = pull EOP low (device terminates block)
// done/err     out  1       block complete / sticky protocol error
// BEHAVIOUR
// - Reset: DREQ=0, DB_OE=0, EOP_N_OUT=1, done=0, err=0, FIFO flushed, state IDLE, count=0.
// - Strobes/DACK/EOP sampled on CLK. Transfer = DACK&strobe low sampled, then strobe high
//   sampled (completion edge); one transfer per edge.
// - FSM IDLE->REQ (enable & !done & ready_cond) ->ACK (DACK=1) ->STROBE (strobe low)
//   ->ACK on completion edge; ACK->REQ/IDLE when DACK drops. Any state ->DONE on block end;
//   DONE->IDLE on cfg_enable low.
// - ready_cond: dir=0 FIFO non-empty; dir=1 FIFO not full.
// - DREQ registered. Demand: DREQ=ready_cond evaluated on post-transfer FIFO level, so
//   DREQ falls in the cycle after the completion edge that empties (dir=0) or fills (dir=1).
//   Single: DREQ falls the cycle after DACK sampled high; may reassert only after DACK low.
// - dir=0: DB_OE = DACK & !IOR_N (combinational); DB_OUT = FIFO head; pop on completion edge.
// - dir=1: DB_IN latched every cycle DACK & !IOW_N; latched word pushed on completion edge.
// - Same-cycle device access and DMA transfer on opposite FIFO ends both take effect; level
//   unchanged. Device side: dev_wready=!full, dev_rvalid=!empty.
// - Count decrements per transfer. With count==1, EOP_N_OUT=0 while strobe low; on that
//   completion edge done=1, DREQ=0 next cycle.
// - EOP_N_IN low sampled with DACK=1 while EOP_N_OUT=1: done=1 at end of the current
//   transfer, which still completes. Own EOP is not self-detected.
// - err set on: strobe with DACK=0 while DREQ never raised; IOW_N while dir=0 or IOR_N while
//   dir=1; push into full FIFO via DMA. Offending cycle is ignored, no FIFO change.
// - cfg_enable low mid-block: DREQ=0 next cycle; an in-progress strobe completes. FIFO kept.
// - Async RESET mid-strobe: outputs immediately to reset values; partial transfer discarded.
// STRUCTURE
// - Package dma_periph_pkg: enum {IDLE,REQ,ACK,STROBE,DONE}, enum dir_t {DEV2MEM,MEM2DEV},
//   DATA_W/CNT_W defaults.
// - Sub-module dma_periph_fifo (sync FIFO, push/pop/full/empty/level, async active-low reset).
// TESTING
// - dir=0, demand, len=4, push A1..A4: DREQ held, 4 IOR_N cycles give A1..A4 on DB_OUT,
//   EOP_N_OUT low on 4th, done=1, DREQ=0.
// - dir=1, single, len=3, DB_IN 5A,5B,5C: DREQ drops after each DACK; dev_rdata 5A,5B,5C.
// - dir=0, len=8, push 2: DREQ falls the cycle after the 2nd completion edge; push 1 more
//   -> DREQ reasserts.
// - EOP_N_IN low in 2nd of len=10 transfers: that transfer completes, done=1, count=8, no more DREQ.
// - IOW_N pulse with DACK=0 and dir=0: err=1, FIFO level unchanged.
// - RESET low during STROBE: DREQ=0, DB_OE=0, FIFO empty same cycle; re-arm works normally.

Source files
------------

// File: rtl/dma_periph_pkg.sv
// Shared types and defaults for the DMA peripheral requester.
package dma_periph_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CNT_W_DEF      = 16;

  // Requester FSM states, visible on the debug port of the top.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    ACK    = 3'd2,
    STROBE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Transfer direction as seen from the device.
  typedef enum logic {
    DEV2MEM = 1'b0,
    MEM2DEV = 1'b1
  } dir_t;

endpackage

// File: rtl/dma_periph_fifo.sv
// Small synchronous FIFO. The caller only raises push/pop when they are legal,
// including push on a full FIFO when a pop happens in the same cycle.
module dma_periph_fifo #(
  parameter int W         = 8,
  parameter int DEPTH     = 8,
  localparam int AW       = $clog2(DEPTH),
  localparam int LVL_W    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage write; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/dma_periph_requester.sv
// Device end of an 8237A-style DMA channel: raises DREQ, answers DACK with
// IOR_N/IOW_N cycles, drives and senses EOP_N, and buffers data in a FIFO.
//
// Device-side handshake: a word moves when valid and ready are both high on a
// rising CLK edge; dev_wready = !full and dev_rvalid = !empty, data is stable
// while valid is high. The push side is only used when cfg_dir = DEV2MEM and
// the pop side only when cfg_dir = MEM2DEV.
module dma_periph_requester
  import dma_periph_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cfg_enable,
  input  logic              cfg_dir,
  input  logic              cfg_demand,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [DATA_W-1:0] dev_wdata,
  input  logic              dev_wvalid,
  output logic              dev_wready,
  output logic [DATA_W-1:0] dev_rdata,
  output logic              dev_rvalid,
  input  logic              dev_rready,
  output logic              DREQ,
  input  logic              DACK,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic [DATA_W-1:0] DB_IN,
  output logic [DATA_W-1:0] DB_OUT,
  output logic              DB_OE,
  input  logic              EOP_N_IN,
  output logic              EOP_N_OUT,
  output logic              done,
  output logic              err,
  output state_t            dbg_state,
  output logic [CNT_W-1:0]  dbg_count,
  output logic [LVL_W-1:0]  dbg_level
);

  state_t             state;
  dir_t               dir;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  lat;
  logic               en_q;
  logic               eop_seen;
  logic               dreq_seen;

  logic               strb_n;
  logic               wrong_n;
  logic               in_xfer;
  logic               complete;
  logic               push_req;
  logic               pop_req;
  logic               push_eff;
  logic               pop_eff;
  logic               push_blocked;
  logic               xfer_done;
  logic               eop_now;
  logic               term;
  logic               ready_cur;
  logic               ready_post;
  logic               dreq_ok;
  logic               arm;
  logic               err_set;
  logic [LVL_W-1:0]   level;
  logic [LVL_W-1:0]   level_next;
  logic [DATA_W-1:0]  fifo_wdata;
  logic [DATA_W-1:0]  fifo_rdata;
  logic               full;
  logic               empty;

  assign dir     = dir_t'(cfg_dir);
  // The strobe that moves data in the armed direction, and the one that must not appear.
  assign strb_n  = (dir == MEM2DEV) ? IOW_N : IOR_N;
  assign wrong_n = (dir == MEM2DEV) ? IOR_N : IOW_N;
  assign in_xfer = (state == ACK) || (state == STROBE);

  // Completion edge: strobe was low last edge (we are in STROBE) and is now high.
  assign complete = (state == STROBE) && strb_n;

  // FIFO ends: DMA pops in DEV2MEM and pushes in MEM2DEV; device uses the other end.
  assign push_req = (dir == MEM2DEV) ? complete : dev_wvalid;
  assign pop_req  = (dir == DEV2MEM) ? complete : dev_rready;
  assign pop_eff  = pop_req && !empty;
  assign push_eff = push_req && (!full || pop_eff);

  // A DMA write into a full FIFO is refused and does not count as a transfer.
  assign push_blocked = (dir == MEM2DEV) && complete && !push_eff;
  assign xfer_done    = complete && !push_blocked;

  assign level_next = level + LVL_W'(push_eff) - LVL_W'(pop_eff);
  assign ready_cur  = (dir == MEM2DEV) ? !full : !empty;
  assign ready_post = (dir == MEM2DEV) ? (level_next != LVL_W'(FIFO_DEPTH))
                                       : (level_next != '0);

  // Demand mode keeps DREQ through DACK; single mode drops it while DACK is high.
  assign dreq_ok = cfg_enable && ready_post && (cfg_demand || !DACK);
  assign arm     = cfg_enable && !en_q;

  // Our own EOP pull-down is excluded so a wired-AND EOP line is not self-detected.
  assign eop_now = in_xfer && DACK && !EOP_N_IN && EOP_N_OUT;
  assign term    = (count == CNT_W'(1)) || eop_seen || eop_now;

  assign err_set = (!DACK && (!IOR_N || !IOW_N) && !dreq_seen)
                || (DACK && !wrong_n)
                || push_blocked;

  assign DB_OE     = in_xfer && (dir == DEV2MEM) && DACK && !IOR_N;
  assign DB_OUT    = fifo_rdata;
  assign EOP_N_OUT = !(in_xfer && DACK && !strb_n && (count == CNT_W'(1)));

  assign fifo_wdata = (dir == MEM2DEV) ? lat : dev_wdata;
  assign dev_wready = !full;
  assign dev_rvalid = !empty;
  assign dev_rdata  = fifo_rdata;

  assign dbg_state = state;
  assign dbg_count = count;
  assign dbg_level = level;

  dma_periph_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET),
    .push  (push_eff),
    .wdata (fifo_wdata),
    .pop   (pop_eff),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Requester FSM with registered DREQ/done/err and the block counter.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      DREQ      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
      lat       <= '0;
      en_q      <= 1'b0;
      eop_seen  <= 1'b0;
      dreq_seen <= 1'b0;
    end else begin
      en_q <= cfg_enable;
      if (DREQ)             dreq_seen <= 1'b1;
      if (err_set)          err       <= 1'b1;
      if (DACK && !IOW_N)   lat       <= DB_IN;
      if (eop_now)          eop_seen  <= 1'b1;
      if (xfer_done)        count     <= count - CNT_W'(1);
      if (arm) begin
        count    <= cfg_len;
        done     <= 1'b0;
        eop_seen <= 1'b0;
      end
      DREQ <= dreq_ok;
      case (state)
        IDLE: begin
          if (cfg_enable && en_q && !done && ready_cur) state <= REQ;
          else                                          DREQ  <= 1'b0;
        end
        REQ: begin
          if (!cfg_enable) begin
            state <= IDLE;
            DREQ  <= 1'b0;
          end else if (DACK) begin
            state <= ACK;
          end
        end
        ACK: begin
          if (!DACK) begin
            if (cfg_enable && ready_post) state <= REQ;
            else begin
              state <= IDLE;
              DREQ  <= 1'b0;
            end
          end else if (!strb_n && wrong_n) begin
            state <= STROBE;
          end
        end
        STROBE: begin
          if (xfer_done) begin
            eop_seen <= 1'b0;
            if (term) begin
              state <= DONE;
              done  <= 1'b1;
              DREQ  <= 1'b0;
            end else begin
              state <= ACK;
            end
          end else if (push_blocked) begin
            state <= ACK;
          end
        end
        DONE: begin
          DREQ <= 1'b0;
          if (!cfg_enable) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          DREQ  <= 1'b0;
        end
      endcase
    end
  end

endmodule
